mem_burst: RTL
==============

MEM_BURST -- requirements
Module: mem_burst

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of words.
REQ-003 Parameter ADDR, default $clog2(DEPTH): address width.
REQ-004 Parameter LENW, default 3: burst-length field width; a burst has len_i+1 beats (1..2^LENW).
REQ-005 Port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst_i, input, 1: reset, asynchronous, active-low.
REQ-007 Port valid_i, input, 1: burst request valid.
REQ-008 Port wr_rd_i, input, 1: request direction; 1 = write burst, 0 = read burst.
REQ-009 Port addr_i, input, ADDR: burst start address.
REQ-010 Port len_i, input, LENW: beat count minus one.
REQ-011 Port ready_o, output, 1: request accepted when valid_i and ready_o are both high at a clock edge.
REQ-012 Port wvalid_i, input, 1: write beat valid.
REQ-013 Port wdata_i, input, WIDTH: write beat data.
REQ-014 Port rdata_o, output, WIDTH: read beat data.
REQ-015 Port rvalid_o, output, 1: rdata_o holds a valid read beat.
REQ-016 Port busy_o, output, 1: a burst is in progress.
REQ-017 Port done_o, output, 1: one-cycle pulse on the last beat of a burst.

Function
REQ-018 The FSM SHALL have three states: IDLE, WRITE, READ.
REQ-019 ready_o SHALL be 1 only in IDLE; busy_o SHALL be 1 only in WRITE or READ.
REQ-020 On request acceptance: addr_i, len_i and wr_rd_i SHALL be captured into a pointer, a beat counter and a direction flag; the next state SHALL be WRITE (wr_rd_i=1) or READ (wr_rd_i=0).
REQ-021 In WRITE, each edge with wvalid_i=1 SHALL write mem[ptr] <= wdata_i, increment ptr and decrement the counter.
REQ-022 In WRITE, edges with wvalid_i=0 SHALL leave memory, ptr and counter unchanged; the burst stalls for as long as needed.
REQ-023 In READ, every edge SHALL load rdata_o <= mem[ptr], set rvalid_o=1, increment ptr and decrement the counter; there is no backpressure.
REQ-024 rvalid_o SHALL be 0 on any edge that does not perform a read beat; rdata_o SHALL hold its last value.
REQ-025 Read latency SHALL be 1 cycle: a beat issued at edge N is valid on rdata_o after edge N.
REQ-026 The pointer SHALL wrap modulo DEPTH; when DEPTH is not a power of two, DEPTH-1 SHALL advance to 0.
REQ-027 On the beat where the counter is 0 (the last beat), done_o SHALL be 1 for that cycle and the FSM SHALL return to IDLE.
REQ-028 In READ, done_o and the last rvalid_o SHALL be asserted in the same cycle.
REQ-029 A burst with len_i=0 SHALL be exactly one beat.
REQ-030 A burst longer than DEPTH SHALL wrap and overwrite or re-read earlier words, in order.
REQ-031 valid_i while busy_o=1 SHALL be ignored; no queueing.
REQ-032 wvalid_i outside WRITE SHALL have no effect.
REQ-033 A new request SHALL be acceptable in the cycle after done_o; idle-to-idle turnaround is 1 cycle.

Reset
REQ-034 rst_i=0 SHALL immediately force: state IDLE, ready_o=0 while rst_i is low (ready_o=1 after release), busy_o=0, done_o=0, rvalid_o=0, rdata_o=0, ptr=0, counter=0.
REQ-035 The memory array SHALL NOT be reset; contents are undefined until written and survive reset.
REQ-036 Reset during a burst SHALL abort it; beats already written SHALL remain in memory, and no done_o is produced.

Verification
REQ-037 Write burst: addr=3, len=3, data A0..A3 with wvalid high every cycle -> mem[3..6]=A0..A3; done_o on the 4th beat; ready_o=1 on the next cycle.
REQ-038 Read burst: addr=3, len=3 -> rvalid_o for 4 consecutive cycles with rdata A0..A3; done_o coincides with A3.
REQ-039 Wrap (DEPTH=16): write addr=14, len=3 with 11,22,33,44 -> mem[14]=11, mem[15]=22, mem[0]=33, mem[1]=44; read-back matches.
REQ-040 Stall: write len=1 with wvalid pattern 1,0,0,1 -> 2 writes, busy_o high for 4 cycles, done_o on cycle 4; valid_i pulsed mid-burst is ignored.
REQ-041 Reset mid-burst: write len=7, assert rst_i low after 3 beats -> outputs at reset values, 3 words written, the rest unchanged; a fresh read of those 3 words is correct.
REQ-042 Single beat: read len=0 at addr=15 -> one rvalid_o cycle with done_o; back-to-back request accepted the next cycle.

Source files
------------

// File: rtl/mem_burst_if.sv
// Burst request, write-beat and read-beat signals shared by a mem_burst
// controller (slave) and whatever drives it (master).
interface mem_burst_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4,
    parameter int LENW  = 3
);
    logic             valid_i;
    logic             wr_rd_i;
    logic [ADDR-1:0]  addr_i;
    logic [LENW-1:0]  len_i;
    logic             ready_o;
    logic             wvalid_i;
    logic [WIDTH-1:0] wdata_i;
    logic [WIDTH-1:0] rdata_o;
    logic             rvalid_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, len_i, wvalid_i, wdata_i,
        input  ready_o, rdata_o, rvalid_o, busy_o, done_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, len_i, wvalid_i, wdata_i,
        output ready_o, rdata_o, rvalid_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_burst.sv
// Single-port word memory with a burst controller: one request sets up a
// write burst (beats paced by wvalid_i) or a read burst (one beat per cycle).
module mem_burst #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = $clog2(DEPTH),
    parameter int LENW  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mem_burst_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t           r_state;
    logic [ADDR-1:0]  r_ptr;
    logic [LENW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;
    logic             r_rd_done;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_beat;
    logic             w_last;
    logic [ADDR-1:0]  w_ptr_next;

    assign w_wr_beat  = (r_state == WRITE) && bus.wvalid_i;
    assign w_last     = (r_cnt == '0);
    // Explicit wrap so non-power-of-two depths step from DEPTH-1 back to 0.
    assign w_ptr_next = (r_ptr == ADDR'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_rvalid  <= 1'b0;
            r_rd_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.valid_i) begin
                        r_ptr   <= bus.addr_i;
                        r_cnt   <= bus.len_i;
                        r_state <= bus.wr_rd_i ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (bus.wvalid_i) begin
                        r_ptr <= w_ptr_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (w_last) r_state <= IDLE;
                    end
                end
                READ: begin
                    r_rdata  <= r_mem[r_ptr];
                    r_rvalid <= 1'b1;
                    r_ptr    <= w_ptr_next;
                    r_cnt    <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_rd_done <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM and its
    // contents survive a controller reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_beat) r_mem[r_ptr] <= bus.wdata_i;
    end

    // A write's done marks the beat being presented; a read's done is
    // registered so it lines up with the final rvalid_o.
    assign bus.ready_o  = rst_i && (r_state == IDLE);
    assign bus.busy_o   = (r_state != IDLE);
    assign bus.done_o   = r_rd_done || (w_wr_beat && w_last);
    assign bus.rdata_o  = r_rdata;
    assign bus.rvalid_o = r_rvalid;
endmodule
